div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Parametrised multi-cycle integer divider for the micro_riscv execute stage.
- Successor to the fixed 8-bit unsigned divider.
- Implements all four RV32M division ops (DIV, DIVU, REM, REMU) at WIDTH bits, producing 1 or 2 quotient bits per cycle.
- The core holds start_i while stalled and writes back result_o on the finish_o cycle.

Parameters:
- WIDTH, 32: operand and result width; must be ≥ 4 and a multiple of STEPS_PER_CYCLE.
- STEPS_PER_CYCLE, 1: restoring-division steps per clock; legal values 1 and 2.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous reset, active low.
- start_i  in  1  request; sampled only while busy_o=0 and finish_o=0.
- op_i  in  2  div_op_t: 00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0]).
- dividend_i  in  WIDTH  rs1 value; sampled on accept.
- divisor_i  in  WIDTH  rs2 value; sampled on accept.
- abort_i  in  1  synchronous cancel of the operation in flight.
- busy_o  out  1  operation in flight, result not yet valid.
- finish_o  out  1  single-cycle pulse; result_o valid.
- result_o  out  WIDTH  quotient or remainder; held until the next accept.
- div_by_zero_o  out  1  divisor was zero for the last completed op; held with result_o.

Behaviour:
- Reset: reset_ni low asynchronously forces:
  - state IDLE;
  - busy_o=0, finish_o=0, result_o=0, div_by_zero_o=0;
  - all internal registers cleared.
- Reset mid-operation discards the operation silently; no finish_o pulse follows.
- FSM states (div_state_t): IDLE, CALC, FIXUP, DONE.
- IDLE, start_i=1 (the accept cycle):
  - Latch op, operand signs, and absolute values (signed ops) or raw values (unsigned ops).
  - Clear the partial remainder and load the step counter with WIDTH/STEPS_PER_CYCLE.
  - Divisor == 0 → DONE:
    - quotient ops return all ones;
    - remainder ops return the dividend;
    - div_by_zero_o=1.
  - Signed op, dividend == MIN and divisor == all ones → DONE:
    - DIV returns MIN;
    - REM returns 0.
  - Otherwise → CALC.
- CALC:
  - Each cycle performs STEPS_PER_CYCLE shift-subtract steps and decrements the counter.
  - Leave for FIXUP when the counter reaches 0.
- FIXUP (signed ops only):
  - Negate the quotient when the dividend and divisor signs differ.
  - Negate the remainder when the dividend is negative.
  - Register result_o from quotient or remainder per op; → DONE.
- DONE:
  - finish_o=1 and busy_o=0 for exactly one cycle; start_i is ignored → IDLE.
  - A held start_i therefore starts a new operation the cycle after finish, never on the finish cycle.
- busy_o=1 in CALC and FIXUP, and in the cycle after accept until DONE.
- Latency, with start accepted in cycle 0:
  - Normal path: finish_o in cycle WIDTH/STEPS_PER_CYCLE + 2.
  - Special cases: finish_o in cycle 1.
  - Latency is fixed and data-independent, with no early-out.
- Handshake:
  - start_i while busy_o=1 or finish_o=1 is ignored.
  - op_i, dividend_i and divisor_i may change after accept without effect.
- abort_i=1 in any state:
  - → IDLE next cycle; busy_o falls, no finish_o.
  - result_o and div_by_zero_o keep their previous values.
  - abort_i has priority over start_i in the same cycle.
- Arithmetic:
  - Partial remainder register is WIDTH+1 bits; subtraction uses a WIDTH+1-bit compare.
  - All negation is two's complement modulo 2^WIDTH.

Decomposition:
- Add to cpu_pkg:
  - div_op_t (2-bit enum: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU);
  - div_state_t (IDLE, CALC, FIXUP, DONE);
  - DIV_WIDTH_DEFAULT=32.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated STEPS_PER_CYCLE times in a generate chain.
- Counter, FSM and sign fixup stay in div_unit.

Test Plan:
- DIVU 100/7, WIDTH=32, S=1 → finish_o in cycle 34, result 14, div_by_zero_o=0; REMU same operands → 2; busy_o=1 in cycles 1–33.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1); REM 7 / 0xFFFFFFFE (−2) → 1.
- DIVU 5/0 → finish_o in cycle 1, result 0xFFFFFFFF, div_by_zero_o=1; REM 0xFFFFFFFB/0 → 0xFFFFFFFB.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, finish in cycle 1; REM same operands → 0; DIVU same operands → 0, normal latency.
- start_i held high across two ops with different operands (S=2, latency 18) → exactly one finish pulse per op, second accept the cycle after the first finish; abort_i at cycle 5 → no finish, busy_o=0 in cycle 6, result_o unchanged.
- reset_ni low at cycle 10 of a DIVU → busy_o, finish_o, result_o, div_by_zero_o all 0 immediately; after release, DIVU 0xFFFFFFFF/3 → 0x55555555.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the multi-cycle RV32M divider.
// The op encoding matches funct3[1:0] of the DIV/DIVU/REM/REMU instructions.
package div_unit_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'b00,
      DIV_OP_DIVU = 2'b01,
      DIV_OP_REM  = 2'b10,
      DIV_OP_REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10,
      DONE  = 2'b11
   } div_state_t;

   function automatic logic is_signed_op(input div_op_t op);
      return ~op[0];
   endfunction

   function automatic logic is_rem_op(input div_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the resulting quotient bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             bit_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_o
);

   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   assign trial = {rem_i[WIDTH-1:0], bit_i};
   assign diff  = trial - {1'b0, divisor_i};

   // A set top bit would mean the shifted value overflowed, so it certainly exceeds the divisor.
   assign q_o   = rem_i[WIDTH] | (trial >= {1'b0, divisor_i});
   assign rem_o = q_o ? diff : trial;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with fixed latency.
// Signed ops divide magnitudes and apply the signs in a final FIXUP cycle.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH           = DIV_WIDTH_DEFAULT,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             finish_o,
   output logic [WIDTH-1:0] result_o,
   output logic             div_by_zero_o
);

   localparam int S    = STEPS_PER_CYCLE;
   localparam int ITER = WIDTH / S;
   localparam int CW   = $clog2(ITER + 1);
   localparam logic [CW-1:0]    ITER_C  = CW'(ITER);
   localparam logic [CW-1:0]    ONE_C   = CW'(1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state_q, state_d;
   div_op_t          op_q, op_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             dbz_q, dbz_d;

   div_op_t          op_in;
   logic             in_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic             in_dz;
   logic             in_ovf;

   assign op_in     = div_op_t'(op_i);
   assign in_signed = is_signed_op(op_in);
   assign a_neg     = in_signed & dividend_i[WIDTH-1];
   assign b_neg     = in_signed & divisor_i[WIDTH-1];
   assign a_abs     = a_neg ? (-dividend_i) : dividend_i;
   assign b_abs     = b_neg ? (-divisor_i) : divisor_i;
   assign in_dz     = (divisor_i == '0);
   assign in_ovf    = in_signed & (dividend_i == MIN_VAL) & (divisor_i == '1);

   // Step chain: the dividend shift register feeds its MSBs in and collects quotient bits at the LSB end.
   logic [WIDTH:0]   rem_chain [0:S];
   logic [S-1:0]     q_bits;
   logic [WIDTH-1:0] dvd_shift;

   assign rem_chain[0] = rem_q;

   generate
      for (genvar gi = 0; gi < S; gi++) begin : g_step
         div_step #(
            .WIDTH(WIDTH)
         ) u_step (
            .rem_i    (rem_chain[gi]),
            .divisor_i(divisor_q),
            .bit_i    (dvd_q[WIDTH-1-gi]),
            .rem_o    (rem_chain[gi+1]),
            .q_o      (q_bits[S-1-gi])
         );
      end
   endgenerate

   assign dvd_shift = {dvd_q[WIDTH-S-1:0], q_bits};

   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   assign quo_fix = (neg_quo_q & is_signed_op(op_q)) ? (-dvd_q) : dvd_q;
   assign rem_fix = (neg_rem_q & is_signed_op(op_q)) ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_d = (in_dz || in_ovf) ? DONE : CALC;
               end
            end
            CALC: begin
               if (cnt_q == ONE_C) begin
                  state_d = FIXUP;
               end
            end
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o        = (state_q == CALC) || (state_q == FIXUP);
      finish_o      = (state_q == DONE);
      result_o      = result_q;
      div_by_zero_o = dbz_q;
   end

   always_comb begin
      op_d      = op_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      divisor_d = divisor_q;
      dvd_d     = dvd_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      dbz_d     = dbz_q;
      if (!abort_i) begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  op_d      = op_in;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  divisor_d = b_abs;
                  dvd_d     = a_abs;
                  rem_d     = '0;
                  cnt_d     = ITER_C;
                  if (in_dz) begin
                     result_d = is_rem_op(op_in) ? dividend_i : '1;
                     dbz_d    = 1'b1;
                  end else if (in_ovf) begin
                     result_d = is_rem_op(op_in) ? '0 : MIN_VAL;
                     dbz_d    = 1'b0;
                  end
               end
            end
            CALC: begin
               rem_d = rem_chain[S];
               dvd_d = dvd_shift;
               cnt_d = cnt_q - ONE_C;
            end
            FIXUP: begin
               result_d = is_rem_op(op_q) ? rem_fix : quo_fix;
               dbz_d    = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         op_q      <= DIV_OP_DIV;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         divisor_q <= '0;
         dvd_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
      end else begin
         op_q      <= op_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         divisor_q <= divisor_d;
         dvd_q     <= dvd_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: one instance with 1 step/cycle and one with 2 steps/cycle,
// checked against a behavioural RV32M model through a scoreboard queue.
module tb_div_unit;

   typedef struct {
      logic [31:0] res;
      logic        dbz;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_s  [2];
   logic        abort_s  [2];
   logic [1:0]  op_s     [2];
   logic [31:0] a_s      [2];
   logic [31:0] b_s      [2];
   logic        busy_s   [2];
   logic        finish_s [2];
   logic [31:0] result_s [2];
   logic        dbz_s    [2];

   exp_t        sb[$];
   logic [31:0] last_res [2];
   logic        last_dbz [2];
   int          tests_run    = 0;
   int          tests_failed = 0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u_s1 (
      .clk_i(clk), .reset_ni(rst_n), .start_i(start_s[0]), .op_i(op_s[0]),
      .dividend_i(a_s[0]), .divisor_i(b_s[0]), .abort_i(abort_s[0]),
      .busy_o(busy_s[0]), .finish_o(finish_s[0]), .result_o(result_s[0]),
      .div_by_zero_o(dbz_s[0])
   );

   div_unit #(.WIDTH(32), .STEPS_PER_CYCLE(2)) u_s2 (
      .clk_i(clk), .reset_ni(rst_n), .start_i(start_s[1]), .op_i(op_s[1]),
      .dividend_i(a_s[1]), .divisor_i(b_s[1]), .abort_i(abort_s[1]),
      .busy_o(busy_s[1]), .finish_o(finish_s[1]), .result_o(result_s[1]),
      .div_by_zero_o(dbz_s[1])
   );

   function automatic exp_t model(input int sel, input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.lat = (sel == 0) ? 34 : 18;
      e.dbz = 1'b0;
      if (b == 32'd0) begin
         e.dbz = 1'b1;
         e.res = op[1] ? a : 32'hFFFF_FFFF;
         e.lat = 1;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = op[1] ? 32'd0 : 32'h8000_0000;
         e.lat = 1;
      end else begin
         case (op)
            2'b00:   e.res = $signed(a) / $signed(b);
            2'b01:   e.res = a / b;
            2'b10:   e.res = $signed(a) % $signed(b);
            default: e.res = a % b;
         endcase
      end
      return e;
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_op(input int sel, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   cyc;
      bit   done;
      sb.push_back(model(sel, op, a, b));
      @(negedge clk);
      start_s[sel] = 1'b1;
      op_s[sel]    = op;
      a_s[sel]     = a;
      b_s[sel]     = b;
      tick();
      start_s[sel] = 1'b0;
      op_s[sel]    = 2'($urandom);
      a_s[sel]     = $urandom;
      b_s[sel]     = $urandom;
      cyc  = 1;
      done = 1'b0;
      while (!done && cyc <= 100) begin
         if (finish_s[sel] === 1'b1) begin
            done = 1'b1;
         end else begin
            tests_run++;
            if (busy_s[sel] !== 1'b1) begin
               tests_failed++;
               $display("FAIL busy_in_flight sel=%0d cyc=%0d got=%b exp=1", sel, cyc, busy_s[sel]);
            end
            tick();
            cyc++;
         end
      end
      e = sb.pop_front();
      tests_run++;
      if (!done) begin
         tests_failed++;
         $display("FAIL finish_timeout sel=%0d op=%0d a=%h b=%h", sel, op, a, b);
      end else begin
         $display("[TB] sel=%0d op=%0d a=%h b=%h -> res=%h dbz=%b cyc=%0d", sel, op, a, b,
                  result_s[sel], dbz_s[sel], cyc);
         tests_run += 3;
         if (result_s[sel] !== e.res) begin
            tests_failed++;
            $display("FAIL result sel=%0d op=%0d got=%h exp=%h", sel, op, result_s[sel], e.res);
         end
         if (dbz_s[sel] !== e.dbz) begin
            tests_failed++;
            $display("FAIL div_by_zero sel=%0d got=%b exp=%b", sel, dbz_s[sel], e.dbz);
         end
         if (cyc != e.lat || busy_s[sel] !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency sel=%0d got=%0d busy=%b exp=%0d busy=0", sel, cyc, busy_s[sel], e.lat);
         end
      end
      tick();
      tests_run++;
      if (finish_s[sel] !== 1'b0 || result_s[sel] !== e.res) begin
         tests_failed++;
         $display("FAIL result_held sel=%0d fin=%b res=%h exp fin=0 res=%h", sel, finish_s[sel],
                  result_s[sel], e.res);
      end
      last_res[sel] = e.res;
      last_dbz[sel] = e.dbz;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         abort_s[i] = 1'b0;
         op_s[i]    = 2'b00;
         a_s[i]     = 32'd0;
         b_s[i]     = 32'd0;
         last_res[i] = 32'd0;
         last_dbz[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (busy_s[i] !== 1'b0 || finish_s[i] !== 1'b0 || result_s[i] !== 32'd0 || dbz_s[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state sel=%0d busy=%b fin=%b res=%h dbz=%b exp all 0", i,
                     busy_s[i], finish_s[i], result_s[i], dbz_s[i]);
         end
      end
      rst_n = 1'b1;
      $display("[TB] reset released");
   endtask

   task automatic test_unsigned;
      run_op(0, 2'b01, 32'd100, 32'd7);
      run_op(0, 2'b11, 32'd100, 32'd7);
      run_op(0, 2'b01, 32'hFFFF_FFFF, 32'd1);
   endtask

   task automatic test_signed;
      run_op(0, 2'b00, 32'hFFFF_FFF9, 32'd2);
      run_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2);
      run_op(0, 2'b10, 32'd7, 32'hFFFF_FFFE);
      run_op(0, 2'b00, 32'h8000_0000, 32'd3);
   endtask

   task automatic test_div_by_zero;
      run_op(0, 2'b01, 32'd5, 32'd0);
      run_op(0, 2'b10, 32'hFFFF_FFFB, 32'd0);
      run_op(1, 2'b00, 32'd1234, 32'd0);
   endtask

   task automatic test_overflow;
      run_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
   endtask

   task automatic test_two_steps;
      for (int i = 0; i < 8; i++) begin
         run_op(1, 2'(i), $urandom, (i == 7) ? 32'd13 : ($urandom >> (i * 3)));
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   fin1 = -1;
      int   fin2 = -1;
      int   nfin = 0;
      int   cyc;
      sb.push_back(model(1, 2'b01, 32'd1000, 32'd3));
      sb.push_back(model(1, 2'b10, 32'hFFFF_FF9C, 32'd7));
      @(negedge clk);
      start_s[1] = 1'b1;
      op_s[1]    = 2'b01;
      a_s[1]     = 32'd1000;
      b_s[1]     = 32'd3;
      tick();
      op_s[1] = 2'b10;
      a_s[1]  = 32'hFFFF_FF9C;
      b_s[1]  = 32'd7;
      cyc = 1;
      while (nfin < 2 && cyc <= 60) begin
         if (fin1 >= 0 && cyc == fin1 + 1) begin
            tests_run++;
            if (busy_s[1] !== 1'b0 || finish_s[1] !== 1'b0) begin
               tests_failed++;
               $display("FAIL b2b_gap busy=%b fin=%b exp 0 0", busy_s[1], finish_s[1]);
            end
         end
         if (finish_s[1] === 1'b1) begin
            e = sb.pop_front();
            nfin++;
            if (nfin == 1) fin1 = cyc;
            else           fin2 = cyc;
            $display("[TB] b2b finish %0d cyc=%0d res=%h", nfin, cyc, result_s[1]);
            tests_run++;
            if (result_s[1] !== e.res) begin
               tests_failed++;
               $display("FAIL b2b_result n=%0d got=%h exp=%h", nfin, result_s[1], e.res);
            end
            last_res[1] = e.res;
            last_dbz[1] = e.dbz;
         end
         if (nfin < 2) begin
            tick();
            cyc++;
         end
      end
      start_s[1] = 1'b0;
      tests_run++;
      if (nfin != 2 || fin1 != 18 || fin2 != 37) begin
         tests_failed++;
         $display("FAIL b2b_timing finishes=%0d at %0d,%0d exp 2 at 18,37", nfin, fin1, fin2);
      end
      tick();
      tests_run++;
      if (finish_s[1] !== 1'b0 || busy_s[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_extra fin=%b busy=%b exp 0 0", finish_s[1], busy_s[1]);
      end
   endtask

   task automatic test_abort;
      int nfin = 0;
      @(negedge clk);
      start_s[1] = 1'b1;
      op_s[1]    = 2'b00;
      a_s[1]     = 32'd12345;
      b_s[1]     = 32'd67;
      tick();
      start_s[1] = 1'b0;
      repeat (4) tick();
      abort_s[1] = 1'b1;
      tick();
      abort_s[1] = 1'b0;
      $display("[TB] abort at cycle 5: busy=%b res=%h", busy_s[1], result_s[1]);
      tests_run++;
      if (busy_s[1] !== 1'b0 || finish_s[1] !== 1'b0 || result_s[1] !== last_res[1] ||
          dbz_s[1] !== last_dbz[1]) begin
         tests_failed++;
         $display("FAIL abort_state busy=%b fin=%b res=%h dbz=%b exp 0 0 %h %b", busy_s[1],
                  finish_s[1], result_s[1], dbz_s[1], last_res[1], last_dbz[1]);
      end
      for (int i = 0; i < 25; i++) begin
         tick();
         if (finish_s[1] === 1'b1) nfin++;
      end
      tests_run++;
      if (nfin != 0) begin
         tests_failed++;
         $display("FAIL abort_no_finish got=%0d pulses exp=0", nfin);
      end
   endtask

   task automatic test_reset_mid;
      int nfin = 0;
      @(negedge clk);
      start_s[0] = 1'b1;
      op_s[0]    = 2'b01;
      a_s[0]     = 32'hDEAD_BEEF;
      b_s[0]     = 32'h0000_0123;
      tick();
      start_s[0] = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      $display("[TB] reset mid-op: busy=%b fin=%b res=%h dbz=%b", busy_s[0], finish_s[0],
               result_s[0], dbz_s[0]);
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (busy_s[i] !== 1'b0 || finish_s[i] !== 1'b0 || result_s[i] !== 32'd0 || dbz_s[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid sel=%0d busy=%b fin=%b res=%h dbz=%b exp all 0", i,
                     busy_s[i], finish_s[i], result_s[i], dbz_s[i]);
         end
         last_res[i] = 32'd0;
         last_dbz[i] = 1'b0;
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (finish_s[0] === 1'b1) nfin++;
      end
      tests_run++;
      if (nfin != 0) begin
         tests_failed++;
         $display("FAIL reset_no_finish got=%0d pulses exp=0", nfin);
      end
      run_op(0, 2'b01, 32'hFFFF_FFFF, 32'd3);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_by_zero();
      test_overflow();
      test_two_steps();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
